// File: rtl/izh_spike_monitor.sv
// Spike detector / ISI meter for the Izhikevich neuron sample stream.
// Hysteretic threshold FSM, saturating ISI gap counter, windowed spike-count reports.
module izh_spike_monitor #(
  parameter int VW    = 8,
  parameter int ISI_W = 12,
  parameter int CNT_W = 8,
  parameter int WIN_W = 12,
  parameter logic signed [VW-1:0] THRESH_HI = 8'sd19,
  parameter logic signed [VW-1:0] THRESH_LO = -8'sd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VW-1:0]    v_in,
  input  logic             v_valid,
  input  logic [WIN_W-1:0] win_len,
  output logic             spike,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic [ISI_W-1:0] rpt_isi,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic             overrun
);

  localparam logic ARMED = 1'b0;
  localparam logic FIRED = 1'b1;

  logic             state_q, state_d;
  logic             seen_q, seen_d;
  logic [ISI_W-1:0] gap_q, gap_d, gap_inc;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             spike_q, isi_valid_q;
  logic [WIN_W-1:0] wcnt_q, wcnt_d, wcnt_inc, wlen_q, wlen_d, eff_len;
  logic [CNT_W-1:0] scnt_q, scnt_d, scnt_inc;
  logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
  logic [ISI_W-1:0] rpt_isi_q, rpt_isi_d;
  logic             rpt_valid_q, rpt_valid_d, overrun_q, overrun_d;
  logic signed [VW-1:0] v_s;
  logic             hit, spike_now, isi_upd, win_on, close, accept;

  always_comb begin
    v_s       = $signed(v_in);
    hit       = (state_q == ARMED) && (v_s >= THRESH_HI);
    spike_now = v_valid && hit;

    state_d = state_q;
    if (v_valid) begin
      if (hit)                                          state_d = FIRED;
      else if (state_q == FIRED && v_s <= THRESH_LO)    state_d = ARMED;
    end

    gap_inc = (gap_q == '1) ? gap_q : gap_q + ISI_W'(1);
    gap_d   = gap_q;
    if (v_valid) gap_d = hit ? '0 : gap_inc;
    isi_upd = spike_now && seen_q;
    isi_d   = isi_upd ? gap_inc : isi_q;
    seen_d  = seen_q | spike_now;

    // A zero captured length means no window yet: keep following win_len live.
    eff_len  = (wlen_q != '0) ? wlen_q : win_len;
    win_on   = v_valid && (eff_len != '0);
    wcnt_inc = wcnt_q + WIN_W'(1);
    close    = win_on && (wcnt_inc == eff_len);
    scnt_inc = (hit && scnt_q != '1) ? scnt_q + CNT_W'(1) : scnt_q;

    wcnt_d = wcnt_q;
    scnt_d = scnt_q;
    wlen_d = wlen_q;
    if (v_valid) wlen_d = close ? win_len : eff_len;
    if (close) begin
      wcnt_d = '0;
      scnt_d = '0;
    end else if (win_on) begin
      wcnt_d = wcnt_inc;
      scnt_d = scnt_inc;
    end

    accept      = rpt_valid_q && rpt_ready;
    rpt_count_d = rpt_count_q;
    rpt_isi_d   = rpt_isi_q;
    rpt_valid_d = rpt_valid_q;
    overrun_d   = overrun_q;
    if (close) begin
      rpt_count_d = scnt_inc;
      rpt_isi_d   = isi_d;
      rpt_valid_d = 1'b1;
      overrun_d   = overrun_q | (rpt_valid_q && !rpt_ready);
    end else if (accept) begin
      rpt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARMED;
      seen_q      <= 1'b0;
      gap_q       <= '0;
      isi_q       <= '0;
      spike_q     <= 1'b0;
      isi_valid_q <= 1'b0;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      wlen_q      <= '0;
      rpt_count_q <= '0;
      rpt_isi_q   <= '0;
      rpt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      gap_q       <= gap_d;
      isi_q       <= isi_d;
      spike_q     <= spike_now;
      isi_valid_q <= isi_upd;
      wcnt_q      <= wcnt_d;
      scnt_q      <= scnt_d;
      wlen_q      <= wlen_d;
      rpt_count_q <= rpt_count_d;
      rpt_isi_q   <= rpt_isi_d;
      rpt_valid_q <= rpt_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spike     = spike_q;
  assign isi       = isi_q;
  assign isi_valid = isi_valid_q;
  assign rpt_count = rpt_count_q;
  assign rpt_isi   = rpt_isi_q;
  assign rpt_valid = rpt_valid_q;
  assign overrun   = overrun_q;

endmodule
